// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch stage bundle: imem request/response and decode handoff
interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        fetch_fault;

    modport master (
        output imem_req, imem_addr, inst, pc, inst_valid, fetch_fault,
        input  imem_ready, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, inst, pc, inst_valid, fetch_fault,
        output imem_ready, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_target
    );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - RV32I fetch stage, one outstanding imem read; IFETCH_MISALIGN_TRAP_EN enables misaligned-redirect trap
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_fetch_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
`ifdef IFETCH_MISALIGN_TRAP_EN
        ,S_FAULT = 2'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        inst_valid_q, inst_valid_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        fault_q, fault_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            pc_q         <= RESET_PC;
            inst_q       <= NOP;
            inst_valid_q <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
            fault_q      <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
        fault_d      = fault_q;
`endif
        case (state_q)
            S_REQ: begin
                if (bus.imem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    inst_d       = bus.imem_rdata;
                    pc_d         = fetch_pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                // Redirect is only meaningful together with the consume handshake.
                if (bus.inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                    if (bus.redirect) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                        fetch_pc_d = bus.redirect_target;
                        if (bus.redirect_target[1:0] != 2'b00) begin
                            pc_d    = bus.redirect_target;
                            fault_d = 1'b1;
                            state_d = S_FAULT;
                        end
`else
                        fetch_pc_d = bus.redirect_target & ~32'h3;
`endif
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Gate with rst_n so no request is shown while reset holds the FSM in REQ.
    assign bus.imem_req   = rst_n && (state_q == S_REQ);
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst       = inst_q;
    assign bus.pc         = pc_q;
    assign bus.inst_valid = inst_valid_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
    assign bus.fetch_fault = fault_q;
`else
    assign bus.fetch_fault = 1'b0;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    inst_fetch_if ifc ();

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
        else n_pass++;
    endtask

    task automatic idle_inputs();
        ifc.imem_ready      = 1'b0;
        ifc.imem_rvalid     = 1'b0;
        ifc.imem_rdata      = 32'h0;
        ifc.inst_ready      = 1'b0;
        ifc.redirect        = 1'b0;
        ifc.redirect_target = 32'h0;
    endtask

    // Drive REQ -> WAIT -> HOLD with no wait states; leaves the FSM in HOLD.
    task automatic fetch_to_hold(input logic [31:0] data);
        ifc.imem_ready = 1'b1;
        tick();
        ifc.imem_ready  = 1'b0;
        ifc.imem_rvalid = 1'b1;
        ifc.imem_rdata  = data;
        tick();
        ifc.imem_rvalid = 1'b0;
    endtask

    task automatic consume(input logic redir, input logic [31:0] tgt);
        ifc.inst_ready      = 1'b1;
        ifc.redirect        = redir;
        ifc.redirect_target = tgt;
        tick();
        ifc.inst_ready = 1'b0;
        ifc.redirect   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("rst_imem_req",    {31'b0, ifc.imem_req},    32'h0);
        chk("rst_imem_addr",   ifc.imem_addr,            32'h0);
        chk("rst_pc",          ifc.pc,                   32'h0);
        chk("rst_inst",        ifc.inst,                 32'h0000_0013);
        chk("rst_inst_valid",  {31'b0, ifc.inst_valid},  32'h0);
        chk("rst_fetch_fault", {31'b0, ifc.fetch_fault}, 32'h0);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) begin
            chk("basic_req",  {31'b0, ifc.imem_req}, 32'h1);
            chk("basic_addr", ifc.imem_addr, 32'(i * 4));
            ifc.imem_ready = 1'b1;
            tick();
            ifc.imem_ready = 1'b0;
            chk("basic_wait_req", {31'b0, ifc.imem_req}, 32'h0);
            ifc.imem_rvalid = 1'b1;
            ifc.imem_rdata  = 32'h0000_0013;
            tick();
            ifc.imem_rvalid = 1'b0;
            chk("basic_valid", {31'b0, ifc.inst_valid}, 32'h1);
            chk("basic_inst",  ifc.inst, 32'h0000_0013);
            chk("basic_pc",    ifc.pc, 32'(i * 4));
            consume(1'b0, 32'h0);
        end
    endtask

    task automatic test_backpressure();
        chk("bp_addr", ifc.imem_addr, 32'h0000_000C);
        fetch_to_hold(32'h0050_0093);
        for (int i = 0; i < 5; i++) begin
            chk("bp_inst",  ifc.inst, 32'h0050_0093);
            chk("bp_pc",    ifc.pc, 32'h0000_000C);
            chk("bp_valid", {31'b0, ifc.inst_valid}, 32'h1);
            chk("bp_req",   {31'b0, ifc.imem_req}, 32'h0);
            tick();
        end
        consume(1'b0, 32'h0);
        chk("bp_next_req",   {31'b0, ifc.imem_req}, 32'h1);
        chk("bp_next_addr",  ifc.imem_addr, 32'h0000_0010);
        chk("bp_valid_drop", {31'b0, ifc.inst_valid}, 32'h0);
    endtask

    task automatic test_mem_stall();
        ifc.imem_rvalid = 1'b1;
        ifc.imem_rdata  = 32'hBAD0_BAD0;
        tick();
        ifc.imem_rvalid = 1'b0;
        chk("stall_spurious_inst",  ifc.inst, 32'h0050_0093);
        chk("stall_spurious_valid", {31'b0, ifc.inst_valid}, 32'h0);
        chk("stall_req_c1",  {31'b0, ifc.imem_req}, 32'h1);
        chk("stall_addr_c1", ifc.imem_addr, 32'h0000_0010);
        ifc.imem_ready = 1'b1;
        tick();
        ifc.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_wait_req",  {31'b0, ifc.imem_req}, 32'h0);
            chk("stall_wait_addr", ifc.imem_addr, 32'h0000_0010);
            tick();
        end
        ifc.imem_rvalid = 1'b1;
        ifc.imem_rdata  = 32'h00A0_0113;
        tick();
        ifc.imem_rvalid = 1'b0;
        chk("stall_c7_valid", {31'b0, ifc.inst_valid}, 32'h1);
        chk("stall_c7_inst",  ifc.inst, 32'h00A0_0113);
        chk("stall_c7_pc",    ifc.pc, 32'h0000_0010);
    endtask

    task automatic test_redirect();
        consume(1'b1, 32'h0000_0100);
        chk("redir_addr", ifc.imem_addr, 32'h0000_0100);
        chk("redir_req",  {31'b0, ifc.imem_req}, 32'h1);
        ifc.imem_ready = 1'b1;
        tick();
        ifc.imem_ready      = 1'b0;
        ifc.redirect        = 1'b1;
        ifc.redirect_target = 32'h0000_0200;
        tick();
        ifc.redirect    = 1'b0;
        ifc.imem_rvalid = 1'b1;
        ifc.imem_rdata  = 32'h0000_0063;
        tick();
        ifc.imem_rvalid = 1'b0;
        chk("redir_wait_pc", ifc.pc, 32'h0000_0100);
        consume(1'b0, 32'h0);
        chk("redir_seq_addr", ifc.imem_addr, 32'h0000_0104);
        fetch_to_hold(32'h0000_0013);
        consume(1'b1, 32'hFFFF_FFFC);
        fetch_to_hold(32'h0000_0013);
        chk("wrap_pc", ifc.pc, 32'hFFFF_FFFC);
        consume(1'b0, 32'h0);
        chk("wrap_addr", ifc.imem_addr, 32'h0000_0000);
    endtask

    task automatic test_misalign();
        fetch_to_hold(32'h0000_0067);
        consume(1'b1, 32'h0000_0102);
`ifdef IFETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            ifc.imem_ready = 1'b1;
            chk("mis_fault", {31'b0, ifc.fetch_fault}, 32'h1);
            chk("mis_req",   {31'b0, ifc.imem_req}, 32'h0);
            chk("mis_valid", {31'b0, ifc.inst_valid}, 32'h0);
            chk("mis_pc",    ifc.pc, 32'h0000_0102);
            tick();
        end
        ifc.imem_ready = 1'b0;
`else
        chk("mis_addr",  ifc.imem_addr, 32'h0000_0100);
        chk("mis_fault", {31'b0, ifc.fetch_fault}, 32'h0);
        chk("mis_req",   {31'b0, ifc.imem_req}, 32'h1);
        fetch_to_hold(32'h0000_0013);
        chk("mis_pc", ifc.pc, 32'h0000_0100);
        consume(1'b0, 32'h0);
`endif
    endtask

    task automatic test_reset_in_wait();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rw_fault_clear", {31'b0, ifc.fetch_fault}, 32'h0);
        fetch_to_hold(32'h0000_0013);
        consume(1'b0, 32'h0);
        ifc.imem_ready = 1'b1;
        tick();
        ifc.imem_ready  = 1'b0;
        ifc.imem_rvalid = 1'b1;
        ifc.imem_rdata  = 32'hDEAD_BEEF;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rw_req",   {31'b0, ifc.imem_req}, 32'h0);
        chk("rw_addr",  ifc.imem_addr, 32'h0);
        chk("rw_pc",    ifc.pc, 32'h0);
        chk("rw_inst",  ifc.inst, 32'h0000_0013);
        chk("rw_valid", {31'b0, ifc.inst_valid}, 32'h0);
        tick();
        ifc.imem_rvalid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rw_rel_req",   {31'b0, ifc.imem_req}, 32'h1);
        chk("rw_rel_addr",  ifc.imem_addr, 32'h0);
        chk("rw_rel_valid", {31'b0, ifc.inst_valid}, 32'h0);
        fetch_to_hold(32'h00A0_0113);
        chk("rw_first_inst", ifc.inst, 32'h00A0_0113);
        chk("rw_first_pc",   ifc.pc, 32'h0);
        consume(1'b0, 32'h0);
        chk("rw_next_addr", ifc.imem_addr, 32'h0000_0004);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_mem_stall();
        test_redirect();
        test_misalign();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
